// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, ALU/mux
// select codes, FSM state encoding and the bundled control word.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_BRANCH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11,
      ILLEGAL = 4'd12
   } stateT;

   typedef struct packed {
      logic       pcWrite;
      logic       pcWriteCond;
      logic       iorD;
      logic       memRead;
      logic       memWrite;
      logic       irWrite;
      logic       memToReg;
      logic       regDst;
      logic       regWrite;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
      logic [1:0] pcSource;
      logic       illegalOp;
   } ctrlT;

endpackage

// File: rtl/event_counter.sv
// Free-running event counter with synchronous clear; wraps modulo 2^CNT_W.
module event_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (inc)
         count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing a multi-cycle MIPS datapath, with optional memory
// wait states, an illegal-opcode trap state and an instructions-retired count.
module multicycle_control
   import mips_pkg::*;
#(
   parameter int OPCODE_W      = 6,
   parameter int ALUOP_W       = 2,
   parameter int MEM_HANDSHAKE = 1,
   parameter int CNT_W         = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                pcWrite,
   output logic                pcWriteCond,
   output logic                iorD,
   output logic                memRead,
   output logic                memWrite,
   output logic                irWrite,
   output logic                memToReg,
   output logic                regDst,
   output logic                regWrite,
   output logic                aluSrcA,
   output logic [1:0]          aluSrcB,
   output logic [ALUOP_W-1:0]  ALUOp,
   output logic [1:0]          pcSource,
   output logic                illegal_op,
   output logic [CNT_W-1:0]    instret
);

   stateT state, nextState;
   ctrlT  ctrl;
   logic  memOk;
   logic  retire;

   assign memOk = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

   always_ff @(posedge clk) begin
      if (reset)
         state <= FETCH;
      else
         state <= nextState;
   end

   always_comb begin
      // NOTE: defaults first, so no path through the case can leave a signal unassigned (no latches).
      nextState = state;
      ctrl      = '0;
      retire    = 1'b0;
      case (state)
         FETCH: begin
            ctrl.memRead = 1'b1;
            ctrl.aluSrcB = SRCB_FOUR;
            ctrl.aluOp   = ALU_ADD;
            if (memOk) begin
               ctrl.irWrite = 1'b1;
               ctrl.pcWrite = 1'b1;
               nextState    = DECODE;
            end
         end
         DECODE: begin
            ctrl.aluSrcB = SRCB_BRANCH;
            case (opcode)
               OP_LW, OP_SW: nextState = MEMADR;
               OP_RTYPE:     nextState = EXECUTE;
               OP_BEQ:       nextState = BRANCH;
               OP_ADDI:      nextState = ADDIEX;
               OP_J:         nextState = JUMP;
               default:      nextState = ILLEGAL;
            endcase
         end
         MEMADR: begin
            ctrl.aluSrcA = 1'b1;
            ctrl.aluSrcB = SRCB_IMM;
            nextState    = (opcode == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            ctrl.memRead = 1'b1;
            ctrl.iorD    = 1'b1;
            if (memOk) nextState = MEMWB;
         end
         MEMWB: begin
            ctrl.regWrite = 1'b1;
            ctrl.memToReg = 1'b1;
            nextState     = FETCH;
            retire        = 1'b1;
         end
         MEMWR: begin
            ctrl.memWrite = 1'b1;
            ctrl.iorD     = 1'b1;
            if (memOk) begin
               nextState = FETCH;
               retire    = 1'b1;
            end
         end
         EXECUTE: begin
            ctrl.aluSrcA = 1'b1;
            ctrl.aluOp   = ALU_FUNCT;
            nextState    = ALUWB;
         end
         ALUWB: begin
            ctrl.regWrite = 1'b1;
            ctrl.regDst   = 1'b1;
            nextState     = FETCH;
            retire        = 1'b1;
         end
         BRANCH: begin
            ctrl.aluSrcA     = 1'b1;
            ctrl.aluOp       = ALU_SUB;
            ctrl.pcWriteCond = 1'b1;
            ctrl.pcSource    = PCSRC_ALUOUT;
            nextState        = FETCH;
            retire           = 1'b1;
         end
         ADDIEX: begin
            ctrl.aluSrcA = 1'b1;
            ctrl.aluSrcB = SRCB_IMM;
            nextState    = ADDIWB;
         end
         ADDIWB: begin
            ctrl.regWrite = 1'b1;
            nextState     = FETCH;
            retire        = 1'b1;
         end
         JUMP: begin
            ctrl.pcWrite  = 1'b1;
            ctrl.pcSource = PCSRC_JUMP;
            nextState     = FETCH;
            retire        = 1'b1;
         end
         ILLEGAL: begin
            ctrl.illegalOp = 1'b1;
            nextState      = FETCH;
         end
         default: nextState = FETCH;
      endcase
      // Reset silences every strobe combinationally and abandons the retirement.
      if (reset) begin
         ctrl   = '0;
         retire = 1'b0;
      end
   end

   assign pcWrite     = ctrl.pcWrite;
   assign pcWriteCond = ctrl.pcWriteCond;
   assign iorD        = ctrl.iorD;
   assign memRead     = ctrl.memRead;
   assign memWrite    = ctrl.memWrite;
   assign irWrite     = ctrl.irWrite;
   assign memToReg    = ctrl.memToReg;
   assign regDst      = ctrl.regDst;
   assign regWrite    = ctrl.regWrite;
   assign aluSrcA     = ctrl.aluSrcA;
   assign aluSrcB     = ctrl.aluSrcB;
   assign ALUOp       = ALUOP_W'(ctrl.aluOp);
   assign pcSource    = ctrl.pcSource;
   assign illegal_op  = ctrl.illegalOp;

   event_counter #(.CNT_W(CNT_W)) instretCounter (
      .clk   (clk),
      .reset (reset),
      .inc   (retire),
      .count (instret)
   );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: vector table, hand-written
// corner sequences and a randomized instruction stream against an aggregate model.
module tb_multicycle_control;

   localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
   localparam logic [5:0] T_BEQ = 6'b000100, T_ADDI = 6'b001000, T_J = 6'b000010;
   localparam logic [5:0] T_BAD = 6'b111111, T_JUNK = 6'b010101;

   // {pcWrite,pcWriteCond,iorD,memRead,memWrite,irWrite,memToReg,regDst,regWrite,aluSrcA,aluSrcB,ALUOp,pcSource,illegal_op}
   localparam logic [16:0] W_ZERO    = 17'b0000000000_00_00_00_0;
   localparam logic [16:0] W_FETCH   = 17'b1001010000_01_00_00_0;
   localparam logic [16:0] W_FETCHW  = 17'b0001000000_01_00_00_0;
   localparam logic [16:0] W_DECODE  = 17'b0000000000_11_00_00_0;
   localparam logic [16:0] W_MEMADR  = 17'b0000000001_10_00_00_0;
   localparam logic [16:0] W_MEMRD   = 17'b0011000000_00_00_00_0;
   localparam logic [16:0] W_MEMWB   = 17'b0000001010_00_00_00_0;
   localparam logic [16:0] W_MEMWR   = 17'b0010100000_00_00_00_0;
   localparam logic [16:0] W_EXEC    = 17'b0000000001_00_10_00_0;
   localparam logic [16:0] W_ALUWB   = 17'b0000000110_00_00_00_0;
   localparam logic [16:0] W_BRANCH  = 17'b0100000001_00_01_01_0;
   localparam logic [16:0] W_ADDIEX  = 17'b0000000001_10_00_00_0;
   localparam logic [16:0] W_ADDIWB  = 17'b0000000010_00_00_00_0;
   localparam logic [16:0] W_JUMP    = 17'b1000000000_00_00_10_0;
   localparam logic [16:0] W_ILLEGAL = 17'b0000000000_00_00_00_1;

   logic        clk = 1'b0;
   logic        reset, memReady, reset2, memReady2;
   logic [5:0]  opcode, opcode2;
   logic        pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
   logic        memToReg, regDst, regWrite, aluSrcA, illegalOp;
   logic [1:0]  aluSrcB, aluOp, pcSource;
   logic [31:0] instret;
   logic        pcWrite2, pcWriteCond2, iorD2, memRead2, memWrite2, irWrite2;
   logic        memToReg2, regDst2, regWrite2, aluSrcA2, illegalOp2;
   logic [1:0]  aluSrcB2, aluOp2, pcSource2;
   logic [3:0]  instret2;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   multicycle_control dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(memReady),
      .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
      .memWrite(memWrite), .irWrite(irWrite), .memToReg(memToReg), .regDst(regDst),
      .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .ALUOp(aluOp),
      .pcSource(pcSource), .illegal_op(illegalOp), .instret(instret)
   );

   multicycle_control #(.CNT_W(4), .MEM_HANDSHAKE(0)) dut2 (
      .clk(clk), .reset(reset2), .opcode(opcode2), .mem_ready(memReady2),
      .pcWrite(pcWrite2), .pcWriteCond(pcWriteCond2), .iorD(iorD2), .memRead(memRead2),
      .memWrite(memWrite2), .irWrite(irWrite2), .memToReg(memToReg2), .regDst(regDst2),
      .regWrite(regWrite2), .aluSrcA(aluSrcA2), .aluSrcB(aluSrcB2), .ALUOp(aluOp2),
      .pcSource(pcSource2), .illegal_op(illegalOp2), .instret(instret2)
   );

   function automatic logic [16:0] ctrlWord();
      return {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg, regDst,
              regWrite, aluSrcA, aluSrcB, aluOp, pcSource, illegalOp};
   endfunction

   function automatic logic [16:0] ctrlWord2();
      return {pcWrite2, pcWriteCond2, iorD2, memRead2, memWrite2, irWrite2, memToReg2, regDst2,
              regWrite2, aluSrcA2, aluSrcB2, aluOp2, pcSource2, illegalOp2};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic        rdy;
      logic [16:0] expCtrl;
      logic [31:0] expCnt;
   } vecT;

   vecT vecs[$];

   task automatic addVec(input logic rst, input logic [5:0] op, input logic rdy,
                         input logic [16:0] expCtrl, input logic [31:0] expCnt);
      vecT v;
      v.rst = rst; v.op = op; v.rdy = rdy; v.expCtrl = expCtrl; v.expCnt = expCnt;
      vecs.push_back(v);
   endtask

   // Inputs are applied just after a rising edge, outputs sampled on the falling edge.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic step1(input logic rst, input logic [5:0] op, input logic rdy,
                        input string name, input logic [16:0] expCtrl);
      reset = rst; opcode = op; memReady = rdy;
      @(negedge clk);
      check(name, 32'(ctrlWord()), 32'(expCtrl));
      nextCycle();
   endtask

   task automatic step2(input logic [5:0] op, input string name, input logic [16:0] expCtrl);
      reset2 = 1'b0; opcode2 = op; memReady2 = 1'b0;
      @(negedge clk);
      check(name, 32'(ctrlWord2()), 32'(expCtrl));
      nextCycle();
   endtask

   initial begin
      reset = 1'b1; opcode = T_JUNK; memReady = 1'b0;
      reset2 = 1'b1; opcode2 = T_JUNK; memReady2 = 1'b0;
      nextCycle();
      nextCycle();

      // Cycle-by-cycle table: lw, stalled fetch + R, beq, j, addi, sw with wait, illegal, stalled lw.
      addVec(0, T_JUNK, 1, W_FETCH, 0);   addVec(0, T_LW, 1, W_DECODE, 0);
      addVec(0, T_LW, 1, W_MEMADR, 0);    addVec(0, T_LW, 1, W_MEMRD, 0);
      addVec(0, T_LW, 0, W_MEMWB, 0);
      addVec(0, T_JUNK, 0, W_FETCHW, 1);  addVec(0, T_JUNK, 0, W_FETCHW, 1);
      addVec(0, T_JUNK, 1, W_FETCH, 1);   addVec(0, T_R, 0, W_DECODE, 1);
      addVec(0, T_R, 0, W_EXEC, 1);       addVec(0, T_R, 1, W_ALUWB, 1);
      addVec(0, T_JUNK, 1, W_FETCH, 2);   addVec(0, T_BEQ, 0, W_DECODE, 2);
      addVec(0, T_BEQ, 0, W_BRANCH, 2);
      addVec(0, T_JUNK, 1, W_FETCH, 3);   addVec(0, T_J, 1, W_DECODE, 3);
      addVec(0, T_J, 0, W_JUMP, 3);
      addVec(0, T_JUNK, 1, W_FETCH, 4);   addVec(0, T_ADDI, 1, W_DECODE, 4);
      addVec(0, T_ADDI, 0, W_ADDIEX, 4);  addVec(0, T_ADDI, 0, W_ADDIWB, 4);
      addVec(0, T_JUNK, 1, W_FETCH, 5);   addVec(0, T_SW, 1, W_DECODE, 5);
      addVec(0, T_SW, 1, W_MEMADR, 5);    addVec(0, T_SW, 0, W_MEMWR, 5);
      addVec(0, T_SW, 1, W_MEMWR, 5);
      addVec(0, T_JUNK, 1, W_FETCH, 6);   addVec(0, T_BAD, 1, W_DECODE, 6);
      addVec(0, T_BAD, 1, W_ILLEGAL, 6);
      addVec(0, T_JUNK, 1, W_FETCH, 6);   addVec(0, T_LW, 1, W_DECODE, 6);
      addVec(0, T_LW, 0, W_MEMADR, 6);    addVec(0, T_LW, 0, W_MEMRD, 6);
      addVec(0, T_LW, 1, W_MEMRD, 6);     addVec(0, T_LW, 1, W_MEMWB, 6);
      addVec(0, T_JUNK, 0, W_FETCHW, 7);

      for (int i = 0; i < vecs.size(); i++) begin
         reset = vecs[i].rst; opcode = vecs[i].op; memReady = vecs[i].rdy;
         @(negedge clk);
         check($sformatf("table[%0d].ctrl", i), 32'(ctrlWord()), 32'(vecs[i].expCtrl));
         check($sformatf("table[%0d].instret", i), instret, vecs[i].expCnt);
         nextCycle();
      end

      // Reset held 3 cycles in the middle of an lw: outputs dark, instruction abandoned.
      step1(0, T_JUNK, 1, "midlw.fetch", W_FETCH);
      step1(0, T_LW, 1, "midlw.decode", W_DECODE);
      step1(0, T_LW, 1, "midlw.memadr", W_MEMADR);
      for (int i = 0; i < 3; i++) step1(1, T_LW, 1, $sformatf("midlw.reset%0d", i), W_ZERO);
      reset = 1'b0; opcode = T_JUNK; memReady = 1'b0;
      @(negedge clk);
      check("postreset.ctrl", 32'(ctrlWord()), 32'(W_FETCHW));
      check("postreset.instret", instret, 32'd0);
      nextCycle();

      // Narrow counter, handshake disabled: 16 jumps wrap instret, lw ignores mem_ready.
      for (int k = 0; k < 16; k++) begin
         reset2 = 1'b0; opcode2 = T_JUNK; memReady2 = 1'b0;
         @(negedge clk);
         check($sformatf("wrap.j%0d.fetch", k), 32'(ctrlWord2()), 32'(W_FETCH));
         check($sformatf("wrap.j%0d.instret", k), 32'(instret2), 32'(k));
         nextCycle();
         step2(T_J, "wrap.decode", W_DECODE);
         step2(T_J, "wrap.jump", W_JUMP);
      end
      step2(T_JUNK, "nohs.fetch", W_FETCH);
      check("wrap.instret_zero", 32'(instret2), 32'd0);
      step2(T_LW, "nohs.decode", W_DECODE);
      step2(T_LW, "nohs.memadr", W_MEMADR);
      step2(T_LW, "nohs.memrd", W_MEMRD);
      step2(T_LW, "nohs.memwb", W_MEMWB);
      reset2 = 1'b0; opcode2 = T_JUNK; memReady2 = 1'b0;
      @(negedge clk);
      check("nohs.refetch", 32'(ctrlWord2()), 32'(W_FETCH));
      check("nohs.instret", 32'(instret2), 32'd1);
      nextCycle();

      // Randomized instruction stream against an aggregate per-instruction model.
      reset = 1'b1;
      nextCycle();
      reset = 1'b0;
      begin
         int unsigned modelCnt;
         modelCnt = 0;
         for (int n = 0; n < 150; n++) begin
            int kind, wf, wm, total, base;
            int nMemRead, nMemWrite, nIrWrite, nPcWrite, nRegWrite, nPcCond, nIllegal;
            logic [5:0] op;
            logic isMem, isLw, isSw;
            kind = int'($urandom_range(0, 6));
            wf = int'($urandom_range(0, 2));
            wm = int'($urandom_range(0, 2));
            case (kind)
               0: begin op = T_R;    base = 4; end
               1: begin op = T_LW;   base = 5; end
               2: begin op = T_SW;   base = 4; end
               3: begin op = T_BEQ;  base = 3; end
               4: begin op = T_ADDI; base = 4; end
               5: begin op = T_J;    base = 3; end
               default: begin
                  base = 3;
                  do op = 6'($urandom);
                  while (op == T_R || op == T_LW || op == T_SW || op == T_BEQ ||
                         op == T_ADDI || op == T_J);
               end
            endcase
            isLw = (kind == 1); isSw = (kind == 2); isMem = isLw || isSw;
            total = base + wf + (isMem ? wm : 0);
            nMemRead = 0; nMemWrite = 0; nIrWrite = 0; nPcWrite = 0;
            nRegWrite = 0; nPcCond = 0; nIllegal = 0;
            for (int c = 0; c < total; c++) begin
               if (c < wf) memReady = 1'b0;
               else if (c == wf) memReady = 1'b1;
               else if (isMem && c >= wf + 3 && c < wf + 3 + wm) memReady = 1'b0;
               else if (isMem && c == wf + 3 + wm) memReady = 1'b1;
               else memReady = 1'($urandom_range(0, 1));
               opcode = (c <= wf) ? 6'($urandom) : op;
               @(negedge clk);
               if (c == 0) begin
                  check("rnd.fetch_memRead", 32'(memRead), 32'd1);
                  check("rnd.fetch_aluSrcB", 32'(aluSrcB), 32'd1);
                  check("rnd.instret", instret, modelCnt);
               end
               nMemRead  += int'(memRead);   nMemWrite += int'(memWrite);
               nIrWrite  += int'(irWrite);   nPcWrite  += int'(pcWrite);
               nRegWrite += int'(regWrite);  nPcCond   += int'(pcWriteCond);
               nIllegal  += int'(illegalOp);
               nextCycle();
            end
            check("rnd.memRead_cycles", 32'(nMemRead), 32'(wf + 1 + (isLw ? wm + 1 : 0)));
            check("rnd.memWrite_cycles", 32'(nMemWrite), 32'(isSw ? wm + 1 : 0));
            check("rnd.irWrite_cycles", 32'(nIrWrite), 32'd1);
            check("rnd.pcWrite_cycles", 32'(nPcWrite), 32'(kind == 5 ? 2 : 1));
            check("rnd.regWrite_cycles", 32'(nRegWrite), 32'((kind <= 1 || kind == 4) ? 1 : 0));
            check("rnd.pcWriteCond_cycles", 32'(nPcCond), 32'(kind == 3 ? 1 : 0));
            check("rnd.illegal_cycles", 32'(nIllegal), 32'(kind == 6 ? 1 : 0));
            if (kind != 6) modelCnt++;
         end
         memReady = 1'b0;
         @(negedge clk);
         check("rnd.final_instret", instret, modelCnt);
         check("rnd.final_fetch", 32'(ctrlWord()), 32'(W_FETCHW));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Successor to the single-cycle opcode decoder: a Moore-style FSM that sequences a multi-cycle MIPS datapath, with one shared memory, an IR and A/B/ALUOut registers.
- Adds the addi and j instructions, an optional memory wait-state handshake, an explicit illegal-opcode path and an instructions-retired counter.
- Every output is a defined 0/1; no x don't-cares are driven anywhere.
- Sits between the instruction register (opcode field) and the datapath mux/enable controls.

Parameters:
- OPCODE_W, 6, opcode field width.
- ALUOP_W, 2, width of ALUOp to the ALU-control decoder.
- MEM_HANDSHAKE, 1, 1 = honour mem_ready; 0 = treat mem_ready as constant 1.
- CNT_W, 32, width of the instret counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  OPCODE_W  IR[31:26], valid from DECODE onward.
- mem_ready  in  1  memory access completes this cycle.
- pcWrite  out  1  unconditional PC load.
- pcWriteCond  out  1  PC load if ALU zero (beq).
- iorD  out  1  memory address select, 0 = PC, 1 = ALUOut.
- memRead  out  1  memory read strobe.
- memWrite  out  1  memory write strobe.
- irWrite  out  1  IR load.
- memToReg  out  1  write-back source, 1 = MDR.
- regDst  out  1  destination register, 1 = rd.
- regWrite  out  1  register file write.
- aluSrcA  out  1  0 = PC, 1 = A.
- aluSrcB  out  2  00 = B, 01 = 4, 10 = signext, 11 = signext<<2.
- ALUOp  out  ALUOP_W  00 = add, 01 = sub, 10 = funct.
- pcSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- instret  out  CNT_W  count of retired instructions.

Behaviour:
- Reset: state <= FETCH and instret <= 0 at the clock edge. While reset=1, all control outputs are forced to 0 combinationally. Reset mid-instruction abandons it: no counter increment, and the first post-reset cycle is FETCH.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
- States and the non-zero outputs in each; anything not listed is 0:
  - FETCH: memRead, aluSrcB=01, ALUOp=00; irWrite and pcWrite only when mem_ready=1. Stays in FETCH while mem_ready=0, so the PC increments exactly once. Then goes to DECODE.
  - DECODE: aluSrcB=11. Next state by opcode: lw/sw -> MEMADR, R -> EXECUTE, beq -> BRANCH, addi -> ADDIEX, j -> JUMP, other -> ILLEGAL.
  - MEMADR: aluSrcA=1, aluSrcB=10. Next is MEMRD for lw, MEMWR for sw.
  - MEMRD: memRead, iorD. Holds while mem_ready=0, then goes to MEMWB.
  - MEMWB: regWrite, memToReg. Then FETCH.
  - MEMWR: memWrite, iorD. Holds while mem_ready=0, then goes to FETCH.
  - EXECUTE: aluSrcA=1, ALUOp=10. Then ALUWB.
  - ALUWB: regWrite, regDst. Then FETCH.
  - BRANCH: aluSrcA=1, ALUOp=01, pcWriteCond, pcSource=01. Then FETCH.
  - ADDIEX: aluSrcA=1, aluSrcB=10. Then ADDIWB.
  - ADDIWB: regWrite. Then FETCH.
  - JUMP: pcWrite, pcSource=10. Then FETCH.
  - ILLEGAL: illegal_op=1 for one cycle, no writes, not retired. Then FETCH.
- Latency with zero wait states: lw 5 cycles; R, sw and addi 4; beq and j 3. Each wait cycle adds 1.
- instret increments by 1 on each transition into FETCH from MEMWB, MEMWR (on mem_ready), ALUWB, BRANCH, ADDIWB or JUMP. It wraps modulo 2^CNT_W without saturating.
- With MEM_HANDSHAKE=0, every memory state lasts exactly one cycle regardless of mem_ready.
- opcode is sampled only in DECODE and MEMADR; the IR must hold it stable from DECODE to the end of the instruction.

Decomposition:
- Shared package mips_pkg holds:
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - ALUOp codes (ALU_ADD, ALU_SUB, ALU_FUNCT);
  - aluSrcB and pcSource encodings;
  - the state encoding (4-bit binary, FETCH=0).
- One natural sub-module: event_counter (CNT_W, sync reset, inc enable), used for instret.

Test Plan:
- Reset held for 3 cycles, mid-lw: all outputs 0 during reset. Next cycle is FETCH with memRead=1, aluSrcB=01, and instret=0.
- lw with mem_ready tied 1: states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles. regWrite=1 and memToReg=1 in cycle 5; instret goes 0 -> 1 on re-entry to FETCH.
- FETCH with mem_ready low for 2 cycles, then high: memRead=1 for 3 cycles, irWrite and pcWrite high only in the 3rd. The R-type that follows retires after 6 cycles total.
- Sequence beq, j, addi, sw: cycle counts 3, 3, 4 and 4; pcSource 01 and 10 in BRANCH and JUMP; instret ends at 4.
- opcode=111111: ILLEGAL entered after DECODE, illegal_op is a single-cycle pulse, no write strobes assert, and instret is unchanged.
- CNT_W=4 with 16 back-to-back j instructions: instret wraps from 15 to 0. With MEM_HANDSHAKE=0 and mem_ready=0, lw still takes 5 cycles.
